ip_update_arbiter: RTL

IP_UPDATE_ARBITER -- requirements
Module: ip_update_arbiter

---
 rtl/ip_update_arbiter.sv | 47 ++++
 1 files changed

// File: rtl/ip_update_arbiter.sv
// ip_update_arbiter: round-robin arbiter granting two requesters single-edge writes
// to a shared instruction pointer, with one-cycle acks and a saturating conflict count.
module ip_update_arbiter #(
    parameter int IP_WIDTH    = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   reqA,
    input  logic [IP_WIDTH-1:0]    valueA,
    input  logic                   reqB,
    input  logic [IP_WIDTH-1:0]    valueB,
    output logic                   ackA,
    output logic                   ackB,
    output logic [IP_WIDTH-1:0]    ip,
    output logic                   lastWinner,
    output logic [COUNT_WIDTH-1:0] conflicts
);
    logic elig_a, elig_b, grant_a, grant_b;
    // a request still showing its own ack has already been served
    assign elig_a  = reqA && !ackA && !hold;
    assign elig_b  = reqB && !ackB && !hold;
    assign grant_a = elig_a && (!elig_b || lastWinner);
    assign grant_b = elig_b && (!elig_a || !lastWinner);
    always_ff @(posedge clock) begin
        if (reset) begin
            ip         <= '0;
            ackA       <= 1'b0;
            ackB       <= 1'b0;
            lastWinner <= 1'b1;
            conflicts  <= '0;
        end else begin
            ackA <= grant_a;
            ackB <= grant_b;
            if (grant_a) begin
                ip         <= valueA;
                lastWinner <= 1'b0;
            end else if (grant_b) begin
                ip         <= valueB;
                lastWinner <= 1'b1;
            end
            if (elig_a && elig_b && !(&conflicts))
                conflicts <= conflicts + 1'b1;
        end
    end
endmodule
